// File: rtl/serial_fir_ctrl.sv
// rtl/serial_fir_ctrl.sv - sequencing controller for the serial FIR datapath
// Accepts one sample, walks the tap address, and aligns accumulator strobes to the MAC pipeline.

module serial_fir_ctrl #(
   parameter int TAPS    = 16,
   parameter int ADDR_W  = 4,
   parameter int MAC_LAT = 2
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic              sample_valid_i,
   output logic              sample_ready_o,
   output logic              shift_en_o,
   output logic [ADDR_W-1:0] tap_addr_o,
   output logic              acc_clr_o,
   output logic              acc_en_o,
   output logic              out_valid_o,
   output logic              busy_o,
   output logic              overrun_o
);

   typedef enum logic [1:0] {IDLE, MAC, DRAIN} state_t;

   localparam logic [ADDR_W-1:0] LAST_TAP   = ADDR_W'(TAPS - 1);
   localparam logic [2:0]        DRAIN_INIT = 3'(MAC_LAT - 1);

   state_t            state_q;
   logic [ADDR_W-1:0] cnt_q;
   logic [2:0]        drain_q;
   logic              ready_q;
   logic              busy_q;
   logic              out_valid_q;
   logic              overrun_q;

   logic              accept;
   logic              last_tap;
   logic [2:0]        stage0;
   logic [2:0]        tail;

   assign accept   = sample_valid_i & ready_q;
   assign last_tap = (cnt_q == LAST_TAP);

   // Strobes entering the delay line: {last product, first product, any product}
   assign stage0 = {(state_q == MAC) & last_tap,
                    (state_q == MAC) & (cnt_q == '0),
                    (state_q == MAC)};

   generate
      if (MAC_LAT == 0) begin : g_no_delay
         assign tail = stage0;
      end else begin : g_delay
         logic [3*MAC_LAT-1:0] pipe_q;
         if (MAC_LAT == 1) begin : g_one
            always_ff @(posedge clk_i or negedge rstn_i) begin
               if (!rstn_i) pipe_q <= '0;
               else         pipe_q <= stage0;
            end
         end else begin : g_many
            always_ff @(posedge clk_i or negedge rstn_i) begin
               if (!rstn_i) pipe_q <= '0;
               else         pipe_q <= {pipe_q[3*MAC_LAT-4:0], stage0};
            end
         end
         assign tail = pipe_q[3*MAC_LAT-1 -: 3];
      end
   endgenerate

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         drain_q     <= '0;
         ready_q     <= 1'b0;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         out_valid_q <= tail[2];
         if (sample_valid_i && !ready_q) overrun_q <= 1'b1;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  state_q <= MAC;
                  cnt_q   <= '0;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
               end else begin
                  ready_q <= 1'b1;
               end
            end
            MAC: begin
               if (last_tap) begin
                  cnt_q <= '0;
                  if (MAC_LAT > 0) begin
                     state_q <= DRAIN;
                     drain_q <= DRAIN_INIT;
                  end else begin
                     state_q <= IDLE;
                     ready_q <= 1'b1;
                     busy_q  <= 1'b0;
                  end
               end else begin
                  cnt_q <= cnt_q + ADDR_W'(1);
               end
            end
            DRAIN: begin
               if (drain_q == 3'd0) begin
                  state_q <= IDLE;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
               end else begin
                  drain_q <= drain_q - 3'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign sample_ready_o = ready_q;
   assign shift_en_o     = accept;
   assign tap_addr_o     = cnt_q;
   assign acc_en_o       = tail[0];
   assign acc_clr_o      = tail[1];
   assign out_valid_o    = out_valid_q;
   assign busy_o         = busy_q;
   assign overrun_o      = overrun_q;

endmodule

// File: tb/tb_serial_fir_ctrl.sv
// tb/tb_serial_fir_ctrl.sv - bench for serial_fir_ctrl
// Timing model derived from the accept cycle, plus a small FIR datapath around a TAPS=4 instance.

module tb_serial_fir_ctrl;

   localparam int TAPS = 16;
   localparam int LAT  = 2;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic v1 = 1'b0;
   logic v2 = 1'b0;
   logic [7:0] din2 = '0;

   logic rdy1, sh1, clr1, en1, ov1, busy1, ovr1;
   logic [3:0] tap1;
   logic rdy2, sh2, clr2, en2, ov2, busy2, ovr2;
   logic [1:0] tap2;

   int errors = 0;
   int checks = 0;

   int cyc = 0;
   int t_acc = -1;
   bit ovr_m = 1'b0;
   bit rdy_on = 1'b0;
   bit in_rst = 1'b1;

   int xs[4] = '{default: 0};
   int hrom[4];
   int acc2 = 0;

   always #5 clk = ~clk;

   serial_fir_ctrl #(.TAPS(TAPS), .ADDR_W(4), .MAC_LAT(LAT)) dut (
      .clk_i(clk), .rstn_i(rstn), .sample_valid_i(v1),
      .sample_ready_o(rdy1), .shift_en_o(sh1), .tap_addr_o(tap1),
      .acc_clr_o(clr1), .acc_en_o(en1), .out_valid_o(ov1),
      .busy_o(busy1), .overrun_o(ovr1)
   );

   serial_fir_ctrl #(.TAPS(4), .ADDR_W(2), .MAC_LAT(0)) dut_dp (
      .clk_i(clk), .rstn_i(rstn), .sample_valid_i(v2),
      .sample_ready_o(rdy2), .shift_en_o(sh2), .tap_addr_o(tap2),
      .acc_clr_o(clr2), .acc_en_o(en2), .out_valid_o(ov2),
      .busy_o(busy2), .overrun_o(ovr2)
   );

   always @(posedge clk) begin
      if (sh2) begin
         xs[3] <= xs[2];
         xs[2] <= xs[1];
         xs[1] <= xs[0];
         xs[0] <= int'(din2);
      end
      if (en2) acc2 <= (clr2 ? 0 : acc2) + xs[tap2] * hrom[tap2];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] e);
      checks++;
      assert (obs === e) else begin
         errors++;
         $error("FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, e);
      end
   endtask

   function automatic bit exp_ready();
      return !in_rst && rdy_on && (t_acc < 0 || cyc >= t_acc + TAPS + LAT + 1);
   endfunction

   task automatic check_cycle();
      int d;
      bit act;
      d   = cyc - t_acc;
      act = (t_acc >= 0);
      chk("ready",     32'(rdy1),  32'(exp_ready()));
      chk("shift_en",  32'(sh1),   32'(v1 & exp_ready()));
      chk("tap_addr",  32'(tap1),  (act && d >= 1 && d <= TAPS) ? 32'(d - 1) : 32'd0);
      chk("acc_en",    32'(en1),   32'(act && d >= 1 + LAT && d <= TAPS + LAT));
      chk("acc_clr",   32'(clr1),  32'(act && d == 1 + LAT));
      chk("out_valid", 32'(ov1),   32'(act && d == TAPS + LAT + 1));
      chk("busy",      32'(busy1), 32'(act && d >= 1 && d <= TAPS + LAT));
      chk("overrun",   32'(ovr1),  32'(ovr_m));
   endtask

   task automatic cyc_step(input bit v);
      bit r;
      v1 = v;
      #1;
      check_cycle();
      r = exp_ready();
      @(posedge clk);
      if (!in_rst) begin
         if (v && r) t_acc = cyc;
         if (v && !r) ovr_m = 1'b1;
         rdy_on = 1'b1;
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic do_reset(input int n);
      rstn   = 1'b0;
      in_rst = 1'b1;
      t_acc  = -1;
      ovr_m  = 1'b0;
      rdy_on = 1'b0;
      for (int i = 0; i < n; i++) cyc_step(1'($urandom_range(0, 1)));
      rstn   = 1'b1;
      in_rst = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 4; i++) hrom[i] = int'($urandom_range(1, 200));
      @(negedge clk);

      // reset and release
      do_reset(3);
      cyc_step(1'b0);
      cyc_step(1'b0);

      // single accept
      cyc_step(1'b1);
      for (int i = 0; i < 24; i++) cyc_step(1'b0);

      // valid held high: back-to-back accepts and overrun
      for (int i = 0; i < 62; i++) cyc_step(1'b1);
      for (int i = 0; i < 22; i++) cyc_step(1'b0);

      // extra valid pulse mid-run
      do_reset(1);
      cyc_step(1'b0);
      cyc_step(1'b1);
      for (int i = 1; i < 24; i++) cyc_step(i == 5);

      // reset in cycle 8 of a run, then a clean run
      do_reset(1);
      cyc_step(1'b0);
      cyc_step(1'b1);
      for (int i = 1; i < 8; i++) cyc_step(1'b0);
      do_reset(1);
      for (int i = 0; i < 20; i++) cyc_step(1'b0);
      cyc_step(1'b1);
      for (int i = 0; i < 22; i++) cyc_step(1'b0);

      // random traffic with occasional resets
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 150) == 0) do_reset(int'($urandom_range(1, 3)));
         else cyc_step($urandom_range(0, 3) == 0);
      end

      // TAPS=4, MAC_LAT=0 with shift register, ROM and MAC: impulse response
      v1 = 1'b0;
      do_reset(1);
      cyc_step(1'b0);
      cyc_step(1'b0);
      for (int n = 0; n < 5; n++) begin
         din2 = (n == 0) ? 8'd1 : 8'd0;
         v2 = 1'b1;
         #1;
         chk("dp_ready", 32'(rdy2), 32'd1);
         chk("dp_shift", 32'(sh2), 32'd1);
         @(posedge clk);
         @(negedge clk);
         v2 = 1'b0;
         for (int k = 0; k < 4; k++) begin
            #1;
            chk("dp_tap", 32'(tap2), 32'(k));
            chk("dp_acc_en", 32'(en2), 32'd1);
            chk("dp_acc_clr", 32'(clr2), 32'(k == 0));
            chk("dp_busy", 32'(busy2), 32'd1);
            @(posedge clk);
            @(negedge clk);
         end
         #1;
         chk("dp_out_valid", 32'(ov2), 32'd1);
         chk("dp_acc_en_off", 32'(en2), 32'd0);
         chk("dp_result", 32'(acc2), (n < 4) ? 32'(hrom[n]) : 32'd0);
      end
      v2 = 1'b0;
      @(negedge clk);
      #1;
      chk("dp_out_valid_pulse", 32'(ov2), 32'd0);
      chk("dp_overrun", 32'(ovr2), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
